alurf_sequencer: RTL and testbench
==================================

Name: alurf_sequencer

Overview:
Multicycle control FSM that accepts one 16-bit instruction word through a valid/ready handshake and decodes it into the ALUandRF control bundle. It drives that bundle through DECODE, EXECUTE and WRITEBACK, asserting regWrite for exactly one cycle. It then latches the result and flags and returns to IDLE. It sits between the instruction source (board switches or future fetch unit) and ALUandRF.

Parameters:
WIDTH, 16, datapath width; sets the immd, resultData and flags widths.
CMP_OP, 3'b111, aluOp code whose result is never written back (compare).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
instr  input  16  instruction word: [15:12] op, [11:8] rdest, [7:4] opext/immHi, [3:0] rsrc/immLo
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  sequencer can accept instr (IDLE only)
resultData  input  WIDTH  ALUandRF result
outputFlags  input  WIDTH  ALUandRF flags
pc  output  WIDTH  always 0 (PC path not sequenced by this block)
srcAddr  output  4  source register
dstAddr  output  4  destination register
immd  output  WIDTH  sign-extended 8-bit immediate
pcInstruction  output  1  always 0
rTypeInstruction  output  1  1 = register operand, 0 = immediate operand
shiftInstruction  output  1  shift path select
regWrite  output  1  RF write enable
aluOp  output  3  ALU operation
shiftAmount  output  4  shift distance
result_q  output  WIDTH  result latched at WRITEBACK
flags_q  output  WIDTH  flags latched at WRITEBACK
done  output  1  one-cycle pulse: instruction retired
err  output  1  one-cycle pulse: illegal instruction rejected

Behaviour:
- Reset, synchronous, highest priority, valid from any state: state=IDLE. All control outputs, result_q, flags_q, done and err are 0. instr_ready=1 in the cycle after reset deasserts. regWrite is 0 on the first edge with reset high, so an aborted WRITEBACK never writes.
- States: IDLE, DECODE, EXECUTE, WRITEBACK, ERR.
- IDLE:
  - instr_ready=1; controls are at their defaults (all 0).
  - On instr_valid&&instr_ready, instr is captured into ir and the FSM goes to DECODE. Otherwise it stays in IDLE.
- Decode rules (combinational on ir; registered onto outputs at the DECODE edge):
  - op=0000, R-type: rTypeInstruction=1, aluOp=opext[2:0], srcAddr=rsrc, dstAddr=rdest. opext[3]=1 is illegal.
  - op=0001..0111, immediate: rTypeInstruction=0, aluOp=op[2:0], immd={{(WIDTH-8){ir[7]}},ir[7:0]}, dstAddr=rdest, srcAddr=0.
  - op=1000, shift: shiftInstruction=1, rTypeInstruction=1, aluOp=opext[2:0], shiftAmount=ir[3:0], srcAddr=rdest, dstAddr=rdest.
  - op=1001..1111: illegal.
- DECODE, 1 cycle:
  - Legal instruction: controls are driven and held; regWrite=0; next state EXECUTE.
  - Illegal instruction: next state ERR; controls stay at 0.
- EXECUTE, 1 cycle: controls held, regWrite=0 (ALU settle cycle); next state WRITEBACK.
- WRITEBACK, 1 cycle:
  - Controls held.
  - regWrite=1 unless aluOp==CMP_OP.
  - result_q<=resultData and flags_q<=outputFlags at the exit edge.
  - done=1 in the following cycle (IDLE), then IDLE.
- ERR, 1 cycle: err=1, regWrite=0, result_q/flags_q unchanged; then IDLE.
- Latency: handshake at edge N; regWrite is high during cycle N+3; done is high during cycle N+4, with instr_ready=1 in that same cycle. Back-to-back issue gives one instruction per 4 cycles.
- instr_valid while busy is ignored (instr_ready=0); the source must hold it until accepted.
- result_q/flags_q hold their values until the next retire or reset.

Decomposition:
- Shared package alurf_pkg: state enum; op field constants (OP_RTYPE=4'b0000, OP_SHIFT=4'b1000); the IMM op range; field bit positions; CMP_OP.
- Sub-module alurf_decode: pure combinational mapping ir -> {control bundle, illegal}. The FSM and output registers stay in alurf_sequencer.

Test Plan:
- Reset: hold reset 2 cycles mid-WRITEBACK -> regWrite=0 on the reset edge; all outputs 0; instr_ready=1 after release.
- R-type: instr=16'h0312 (rdest 3, opext 1, rsrc 2) -> DECODE outputs srcAddr=2, dstAddr=3, aluOp=1, rTypeInstruction=1; regWrite high exactly cycle N+3; done at N+4; result_q equals the model ALU result.
- Immediate: instr=16'h25F0 -> aluOp=2, rTypeInstruction=0, dstAddr=5, immd=16'hFFF0 (sign-extended).
- Shift and compare:
  - instr=16'h8A37 -> shiftInstruction=1, shiftAmount=7, srcAddr=dstAddr=10, aluOp=3.
  - instr=16'h0171 (opext 7 = CMP) -> regWrite never asserts; flags_q updated.
- Illegal: instr=16'hF000 and 16'h0080 -> err pulse in cycle N+2; no regWrite; result_q unchanged; IDLE at N+3.
- Handshake: instr_valid held high continuously with 3 queued instructions -> accepts only in IDLE cycles, one retire per 4 cycles, no instruction dropped or duplicated.

Source files
------------

// File: rtl/alurf_pkg.sv
// alurf_pkg: shared FSM states, instruction field layout and control bundle for the ALUandRF sequencer
package alurf_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK, S_ERR} state_t;
  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_SHIFT  = 4'b1000;
  localparam logic [3:0] OP_IMM_LO = 4'b0001;
  localparam logic [3:0] OP_IMM_HI = 4'b0111;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int EXT_LSB = 4;
  localparam int RS_LSB  = 0;
  localparam logic [2:0] ALU_CMP = 3'b111;
  // Immediate kept as its raw 8 bits; the top sign-extends to the datapath width.
  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
    logic [7:0] imm8;
    logic       rtype;
    logic       shift;
    logic [2:0] alu_op;
    logic [3:0] shamt;
  } ctrl_t;
endpackage

// File: rtl/alurf_decode.sv
// alurf_decode: combinational instruction decode into the control bundle plus illegal flag
module alurf_decode
  import alurf_pkg::*;
(
  input  logic [15:0] ir_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);
  logic [3:0] op, rd, ext, rs;
  assign op  = ir_i[OP_LSB +: 4];
  assign rd  = ir_i[RD_LSB +: 4];
  assign ext = ir_i[EXT_LSB +: 4];
  assign rs  = ir_i[RS_LSB +: 4];
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    if (op == OP_RTYPE) begin
      ctrl_o.rtype  = 1'b1;
      ctrl_o.alu_op = ext[2:0];
      ctrl_o.src    = rs;
      ctrl_o.dst    = rd;
      illegal_o     = ext[3];
    end else if (op == OP_SHIFT) begin
      ctrl_o.rtype  = 1'b1;
      ctrl_o.shift  = 1'b1;
      ctrl_o.alu_op = ext[2:0];
      ctrl_o.shamt  = rs;
      ctrl_o.src    = rd;
      ctrl_o.dst    = rd;
    end else if (op >= OP_IMM_LO && op <= OP_IMM_HI) begin
      ctrl_o.alu_op = op[2:0];
      ctrl_o.imm8   = {ext, rs};
      ctrl_o.dst    = rd;
    end else begin
      illegal_o = 1'b1;
    end
  end
endmodule

// File: rtl/alurf_sequencer.sv
// alurf_sequencer: multicycle FSM issuing one instruction at a time to ALUandRF and latching its result
module alurf_sequencer
  import alurf_pkg::*;
#(
  parameter int         WIDTH  = 16,
  parameter logic [2:0] CMP_OP = ALU_CMP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [WIDTH-1:0] resultData,
  input  logic [WIDTH-1:0] outputFlags,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       srcAddr,
  output logic [3:0]       dstAddr,
  output logic [WIDTH-1:0] immd,
  output logic             pcInstruction,
  output logic             rTypeInstruction,
  output logic             shiftInstruction,
  output logic             regWrite,
  output logic [2:0]       aluOp,
  output logic [3:0]       shiftAmount,
  output logic [WIDTH-1:0] result_q,
  output logic [WIDTH-1:0] flags_q,
  output logic             done,
  output logic             err
);
  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  ctrl_t            ctrl_q, ctrl_d, dec;
  logic             illegal, reg_write_q, reg_write_d, done_q, done_d;
  logic [WIDTH-1:0] result_d, flags_d;
  alurf_decode u_decode (.ir_i(ir_q), .ctrl_o(dec), .illegal_o(illegal));
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ctrl_d      = ctrl_q;
    reg_write_d = 1'b0;
    done_d      = 1'b0;
    result_d    = result_q;
    flags_d     = flags_q;
    case (state_q)
      S_IDLE: if (instr_valid && instr_ready) begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = illegal ? S_ERR : S_EXECUTE;
        ctrl_d  = illegal ? '0 : dec;
      end
      S_EXECUTE: begin
        state_d     = S_WRITEBACK;
        reg_write_d = ctrl_q.alu_op != CMP_OP;
      end
      S_WRITEBACK: begin
        state_d  = S_IDLE;
        ctrl_d   = '0;
        done_d   = 1'b1;
        result_d = resultData;
        flags_d  = outputFlags;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      ctrl_q      <= '0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ctrl_q      <= ctrl_d;
      reg_write_q <= reg_write_d;
      done_q      <= done_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end
  assign instr_ready      = (state_q == S_IDLE) && !reset;
  assign err              = state_q == S_ERR;
  assign done             = done_q;
  assign regWrite         = reg_write_q;
  assign pc               = '0;
  assign pcInstruction    = 1'b0;
  assign srcAddr          = ctrl_q.src;
  assign dstAddr          = ctrl_q.dst;
  assign immd             = {{(WIDTH-8){ctrl_q.imm8[7]}}, ctrl_q.imm8};
  assign rTypeInstruction = ctrl_q.rtype;
  assign shiftInstruction = ctrl_q.shift;
  assign aluOp            = ctrl_q.alu_op;
  assign shiftAmount      = ctrl_q.shamt;
endmodule

// File: tb/tb_alurf_sequencer.sv
// tb_alurf_sequencer: table vectors, handshake/reset sequences and random instructions against a decode model
module tb_alurf_sequencer;
  logic clk = 1'b0, reset = 1'b1, instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic instr_ready, pcInstruction, rTypeInstruction, shiftInstruction, regWrite, done, err;
  logic [15:0] resultData, outputFlags, pc, immd, result_q, flags_q;
  logic [3:0] srcAddr, dstAddr, shiftAmount;
  logic [2:0] aluOp;
  logic [63:0] dut_ctl;
  int n_tests = 0, n_fail = 0;
  logic [15:0] exp_res = '0, exp_flags = '0;

  typedef struct {
    logic [3:0] src, dst; logic [15:0] immd; logic rtype, shift; logic [2:0] alu; logic [3:0] shamt; logic ill;
  } exp_t;
  typedef struct { logic [15:0] ins; exp_t e; } vec_t;
  vec_t tbl[9];

  alurf_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .resultData(resultData), .outputFlags(outputFlags), .pc(pc), .srcAddr(srcAddr), .dstAddr(dstAddr),
    .immd(immd), .pcInstruction(pcInstruction), .rTypeInstruction(rTypeInstruction),
    .shiftInstruction(shiftInstruction), .regWrite(regWrite), .aluOp(aluOp), .shiftAmount(shiftAmount),
    .result_q(result_q), .flags_q(flags_q), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in for ALUandRF: result and flags are a fixed mix of whatever controls it is shown.
  assign resultData  = immd + {srcAddr, dstAddr, shiftAmount, aluOp, rTypeInstruction};
  assign outputFlags = ~resultData ^ {15'b0, shiftInstruction};
  assign dut_ctl = {31'b0, pc[0] | pcInstruction, srcAddr, dstAddr, immd, rTypeInstruction,
                    shiftInstruction, aluOp, shiftAmount};

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    logic [3:0] op, rd, ext, lo;
    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; lo = ins[3:0];
    e = '{default:'0};
    if (op == 4'd0 && ext < 4'd8) begin
      e.rtype = 1'b1; e.alu = ext[2:0]; e.src = lo; e.dst = rd;
    end else if (op >= 4'd1 && op <= 4'd7) begin
      e.alu = op[2:0]; e.dst = rd;
      e.immd = {8'h00, ins[7:0]} - (ins[7] ? 16'd256 : 16'd0);
    end else if (op == 4'd8) begin
      e.rtype = 1'b1; e.shift = 1'b1; e.alu = ext[2:0]; e.shamt = lo; e.src = rd; e.dst = rd;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [63:0] pack(input exp_t e);
    return {31'b0, 1'b0, e.src, e.dst, e.immd, e.rtype, e.shift, e.alu, e.shamt};
  endfunction

  function automatic logic [15:0] stub_res(input exp_t e);
    return e.immd + {e.src, e.dst, e.shamt, e.alu, e.rtype};
  endfunction

  function automatic logic [15:0] stub_flags(input exp_t e);
    return ~stub_res(e) ^ {15'b0, e.shift};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_one(input logic [15:0] ins, input exp_t e);
    int w = 0;
    @(negedge clk);
    while (!instr_ready && w < 10) begin @(negedge clk); w++; end
    chk("ready_before_issue", 64'(instr_ready), 64'(1));
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("decode_ready", 64'(instr_ready), 64'(0));
    chk("decode_ctl", dut_ctl, 64'(0));
    chk("decode_rw", 64'(regWrite), 64'(0));
    @(negedge clk);
    if (e.ill) begin
      chk("err_pulse", 64'(err), 64'(1));
      chk("err_ctl", dut_ctl, 64'(0));
      chk("err_rw", 64'(regWrite), 64'(0));
      @(negedge clk);
      chk("err_clear", 64'(err), 64'(0));
      chk("err_idle", 64'(instr_ready), 64'(1));
      chk("err_done", 64'(done), 64'(0));
      chk("err_result_kept", 64'(result_q), 64'(exp_res));
      chk("err_flags_kept", 64'(flags_q), 64'(exp_flags));
    end else begin
      chk("exec_ctl", dut_ctl, pack(e));
      chk("exec_rw", 64'(regWrite), 64'(0));
      chk("exec_err", 64'(err), 64'(0));
      @(negedge clk);
      chk("wb_ctl", dut_ctl, pack(e));
      chk("wb_rw", 64'(regWrite), 64'(e.alu != 3'd7));
      chk("wb_done", 64'(done), 64'(0));
      exp_res = stub_res(e); exp_flags = stub_flags(e);
      @(negedge clk);
      chk("retire_done", 64'(done), 64'(1));
      chk("retire_ready", 64'(instr_ready), 64'(1));
      chk("retire_rw", 64'(regWrite), 64'(0));
      chk("retire_ctl", dut_ctl, 64'(0));
      chk("retire_result", 64'(result_q), 64'(exp_res));
      chk("retire_flags", 64'(flags_q), 64'(exp_flags));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] q[3];
    int acc_cyc[3];
    int acc, ret, rw_cnt;
    logic [15:0] ins;
    tbl[0] = '{16'h0312, '{4'h2, 4'h3, 16'h0000, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0}};
    tbl[1] = '{16'h25F0, '{4'h0, 4'h5, 16'hFFF0, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0}};
    tbl[2] = '{16'h8A37, '{4'hA, 4'hA, 16'h0000, 1'b1, 1'b1, 3'd3, 4'd7, 1'b0}};
    tbl[3] = '{16'h0171, '{4'h1, 4'h1, 16'h0000, 1'b1, 1'b0, 3'd7, 4'd0, 1'b0}};
    tbl[4] = '{16'hF000, '{4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1}};
    tbl[5] = '{16'h0080, '{4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1}};
    tbl[6] = '{16'h1C7F, '{4'h0, 4'hC, 16'h007F, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0}};
    tbl[7] = '{16'h7A85, '{4'h0, 4'hA, 16'hFF85, 1'b0, 1'b0, 3'd7, 4'd0, 1'b0}};
    tbl[8] = '{16'h9000, '{4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1}};
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 64'(instr_ready), 64'(0));
    chk("rst_ctl", dut_ctl, 64'(0));
    chk("rst_outs", 64'({regWrite, done, err}), 64'(0));
    chk("rst_result", 64'(result_q), 64'(0));
    chk("rst_flags", 64'(flags_q), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 64'(instr_ready), 64'(1));
    for (int i = 0; i < 9; i++) run_one(tbl[i].ins, tbl[i].e);
    // Reset landing on the WRITEBACK edge must suppress the write and clear the latches.
    @(negedge clk);
    instr = 16'h0312; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("midwb_rw_high", 64'(regWrite), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("midwb_rw", 64'(regWrite), 64'(0));
    chk("midwb_ctl", dut_ctl, 64'(0));
    chk("midwb_done", 64'(done), 64'(0));
    chk("midwb_result", 64'(result_q), 64'(0));
    chk("midwb_flags", 64'(flags_q), 64'(0));
    chk("midwb_ready", 64'(instr_ready), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    exp_res = '0; exp_flags = '0;
    @(negedge clk);
    chk("midwb_release_ready", 64'(instr_ready), 64'(1));
    chk("midwb_release_rw", 64'(regWrite), 64'(0));
    // Valid held high with three queued instructions.
    q = '{16'h1234, 16'h0520, 16'h8B25};
    acc = 0; ret = 0; rw_cnt = 0; acc_cyc = '{0, 0, 0};
    instr = q[0]; instr_valid = 1'b1;
    for (int c = 0; c < 40 && ret < 3; c++) begin
      if (regWrite) rw_cnt++;
      if (done) begin
        chk("hs_result", 64'(result_q), 64'(stub_res(model(q[ret]))));
        ret++;
      end
      if (instr_ready && instr_valid && acc < 3) begin acc_cyc[acc] = c; acc++; end
      @(posedge clk); #1;
      if (acc < 3) instr = q[acc]; else instr_valid = 1'b0;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("hs_accepts", 64'(acc), 64'(3));
    chk("hs_retires", 64'(ret), 64'(3));
    chk("hs_writes", 64'(rw_cnt), 64'(3));
    chk("hs_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(4));
    chk("hs_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(4));
    exp_res = stub_res(model(q[2])); exp_flags = stub_flags(model(q[2]));
    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom);
      run_one(ins, model(ins));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
